// File: rtl/bvc_pkg.sv
// Shared types and constants for the bus vector checker: FSM states,
// vector-memory field selects and flag bit positions.
package bvc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] F_INSTR = 3'd0;
  localparam logic [2:0] F_DADDR = 3'd1;
  localparam logic [2:0] F_LOAD  = 3'd2;
  localparam logic [2:0] F_STORE = 3'd3;
  localparam logic [2:0] F_FLAGS = 3'd4;

  localparam int FLAG_STORE_CHK = 0;
  localparam int FLAG_LOAD_VLD  = 1;
  localparam int FLAG_DADDR_CHK = 2;

  localparam logic [63:0] NOP = 64'd0;

endpackage

// File: rtl/bvc_vec_mem.sv
// Five-field vector register file: one write port, an issue read port for the
// instruction word and a check read port for the expected/return fields.
module bvc_vec_mem
  import bvc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    field,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] issue_idx,
  output logic [DW-1:0] issue_instr,
  input  logic [AW-1:0] chk_idx,
  output logic [DW-1:0] chk_daddr,
  output logic [DW-1:0] chk_load,
  output logic [DW-1:0] chk_store,
  output logic [2:0]    chk_flags
);

  logic [DW-1:0] instr_mem [DEPTH];
  logic [DW-1:0] daddr_mem [DEPTH];
  logic [DW-1:0] load_mem  [DEPTH];
  logic [DW-1:0] store_mem [DEPTH];
  logic [2:0]    flags_mem [DEPTH];

  // Contents survive reset so a program can be loaded once and rerun.
  always_ff @(posedge clk) begin
    if (we) begin
      case (field)
        F_INSTR: instr_mem[waddr] <= wdata;
        F_DADDR: daddr_mem[waddr] <= wdata;
        F_LOAD:  load_mem[waddr]  <= wdata;
        F_STORE: store_mem[waddr] <= wdata;
        F_FLAGS: flags_mem[waddr] <= wdata[2:0];
        default: ;
      endcase
    end
  end

  assign issue_instr = instr_mem[issue_idx];
  assign chk_daddr   = daddr_mem[chk_idx];
  assign chk_load    = load_mem[chk_idx];
  assign chk_store   = store_mem[chk_idx];
  assign chk_flags   = flags_mem[chk_idx];

endmodule

// File: rtl/bus_vector_checker.sv
// Replays a stored instruction program onto ibus and checks the DUT's data
// address / store data LAT cycles after each issue, returning load data.
module bus_vector_checker
  import bvc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int LAT   = 3,
  parameter int ERRW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [2:0]      prog_field,
  input  logic [DW-1:0]   prog_wdata,
  input  logic [AW:0]     num_vec,
  input  logic            start,
  output logic [DW-1:0]   ibus,
  input  logic [DW-1:0]   daddrbus,
  input  logic [DW-1:0]   databus_in,
  output logic [DW-1:0]   databus_out,
  output logic            databus_oe,
  output logic            busy,
  output logic            done,
  output logic [ERRW-1:0] err_cnt,
  output logic [AW-1:0]   first_err_idx,
  output logic            first_err_vld
);

  state_t        state, state_nxt;
  logic [AW-1:0] k;
  logic [3:0]    drain_cnt;
  logic          issue, clr;

  logic          vld_p [LAT];
  logic [AW-1:0] idx_p [LAT];

  logic [DW-1:0] issue_instr, chk_daddr, chk_load, chk_store;
  logic [2:0]    chk_flags;
  logic          chk_vld, daddr_err, store_err;
  logic [1:0]    nerr;

  function automatic logic [ERRW-1:0] sat_add(input logic [ERRW-1:0] a, input logic [1:0] b);
    logic [ERRW:0] s;
    s = {1'b0, a} + {{(ERRW-1){1'b0}}, b};
    return s[ERRW] ? {ERRW{1'b1}} : s[ERRW-1:0];
  endfunction

  bvc_vec_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk         (clk),
    .we          (prog_we),
    .waddr       (prog_addr),
    .field       (prog_field),
    .wdata       (prog_wdata),
    .issue_idx   (k),
    .issue_instr (issue_instr),
    .chk_idx     (idx_p[LAT-1]),
    .chk_daddr   (chk_daddr),
    .chk_load    (chk_load),
    .chk_store   (chk_store),
    .chk_flags   (chk_flags)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (num_vec == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if ({1'b0, k} == num_vec - (AW+1)'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 4'(LAT-1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Check stage: the slot issued LAT edges ago is compared at this edge.
  assign chk_vld   = vld_p[LAT-1];
  assign daddr_err = chk_vld && chk_flags[FLAG_DADDR_CHK] && (daddrbus !== chk_daddr);
  assign store_err = chk_vld && chk_flags[FLAG_STORE_CHK] && (databus_in !== chk_store);
  assign nerr      = {1'b0, daddr_err} + {1'b0, store_err};

  // Load data is driven for the whole cycle leading into the check edge.
  assign databus_oe  = chk_vld && chk_flags[FLAG_LOAD_VLD];
  assign databus_out = databus_oe ? chk_load : '0;

  always_ff @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) idx_p[i] <= idx_p[i-1];
    idx_p[0] <= k;
    if (reset) begin
      state         <= IDLE;
      k             <= '0;
      drain_cnt     <= '0;
      ibus          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
      ibus      <= issue ? issue_instr : NOP[DW-1:0];
      if (clr)        k <= '0;
      else if (issue) k <= k + AW'(1);
      for (int i = LAT-1; i > 0; i--) vld_p[i] <= vld_p[i-1];
      vld_p[0] <= issue;
      if (clr) begin
        err_cnt       <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
      end else if (nerr != 2'd0) begin
        err_cnt <= sat_add(err_cnt, nerr);
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= idx_p[LAT-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_vector_checker.sv
// Directed bench: a table-driven CPU model answers each issued instruction on
// the data buses; load returns are scoreboarded through a queue.
module tb_bus_vector_checker;
  localparam int DW = 32, DEPTH = 32, AW = 5, LAT = 3, ERRW = 16;

  logic            clk = 1'b0;
  logic            reset, prog_we, start;
  logic [AW-1:0]   prog_addr;
  logic [2:0]      prog_field;
  logic [DW-1:0]   prog_wdata;
  logic [AW:0]     num_vec;
  logic [DW-1:0]   ibus, daddrbus, databus_in, databus_out;
  logic            databus_oe, busy, done, first_err_vld;
  logic [ERRW-1:0] err_cnt;
  logic [AW-1:0]   first_err_idx;

  logic [DW-1:0]   ibus_s, databus_out_s;
  logic            databus_oe_s, busy_s, done_s, first_err_vld_s;
  logic [4:0]      err_cnt_s;
  logic [AW-1:0]   first_err_idx_s;

  bus_vector_checker #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .ERRW(ERRW)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_field(prog_field), .prog_wdata(prog_wdata), .num_vec(num_vec), .start(start),
    .ibus(ibus), .daddrbus(daddrbus), .databus_in(databus_in), .databus_out(databus_out),
    .databus_oe(databus_oe), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
  );

  bus_vector_checker #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .ERRW(5)) dut_small (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_field(prog_field), .prog_wdata(prog_wdata), .num_vec(num_vec), .start(start),
    .ibus(ibus_s), .daddrbus(daddrbus), .databus_in(databus_in), .databus_out(databus_out_s),
    .databus_oe(databus_oe_s), .busy(busy_s), .done(done_s), .err_cnt(err_cnt_s),
    .first_err_idx(first_err_idx_s), .first_err_vld(first_err_vld_s)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] t_instr [DEPTH];
  logic [DW-1:0] t_daddr [DEPTH];
  logic [DW-1:0] t_load  [DEPTH];
  logic [DW-1:0] t_store [DEPTH];
  logic [2:0]    t_flags [DEPTH];
  logic [DW-1:0] hist [LAT];
  logic [DW-1:0] load_q [$];
  int mode, fault_idx, total, bad;

  function automatic int lookup(input logic [DW-1:0] w);
    if (w === '0) return -1;
    for (int i = 0; i < DEPTH; i++) if (t_instr[i] === w) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CPU model: answers the instruction seen on ibus LAT-1 negedges earlier.
  task automatic model_step();
    int ix;
    for (int i = LAT-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ibus;
    ix = lookup(ibus);
    if (ix >= 0 && t_flags[ix][1]) load_q.push_back(t_load[ix]);
    if (databus_oe === 1'b1) begin
      if (load_q.size() == 0) check("load_unexpected", 64'(databus_oe), 64'(0));
      else                    check("load_data", 64'(databus_out), 64'(load_q.pop_front()));
    end
    ix = lookup(hist[LAT-1]);
    if (ix < 0) begin
      daddrbus   = '0;
      databus_in = '0;
    end else begin
      daddrbus   = t_daddr[ix];
      databus_in = (ix == fault_idx) ? t_store[ix] + 32'd1 : t_store[ix];
      case (mode)
        1: daddrbus = 'x;
        2: daddrbus = 'z;
        3: begin daddrbus = ~t_daddr[ix]; databus_in = ~t_store[ix]; end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic prog_vec(input int i);
    for (int f = 0; f < 5; f++) begin
      prog_we    = 1'b1;
      prog_addr  = AW'(i);
      prog_field = 3'(f);
      case (f)
        0: prog_wdata = t_instr[i];
        1: prog_wdata = t_daddr[i];
        2: prog_wdata = t_load[i];
        3: prog_wdata = t_store[i];
        default: prog_wdata = {29'd0, t_flags[i]};
      endcase
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic run_vec(input int n, input int exp_err, input int exp_idx, input string tag);
    int cyc;
    bit got;
    num_vec = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1 && n > 0) check({tag, "_ibus0"}, 64'(ibus), 64'(t_instr[0]));
      if (done === 1'b1) got = 1;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'(n + LAT));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_first_vld"}, 64'(first_err_vld), 64'(exp_err != 0));
    check({tag, "_first_idx"}, 64'(first_err_idx), 64'(exp_idx));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_loads_left"}, 64'(load_q.size()), 64'(0));
  endtask

  initial begin
    total = 0; bad = 0; mode = 0; fault_idx = -1;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_field = '0; prog_wdata = '0;
    num_vec = '0; start = 1'b0; daddrbus = '0; databus_in = '0;
    for (int i = 0; i < LAT; i++) hist[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ibus", 64'(ibus), 64'(0));
    check("rst_dout", 64'(databus_out), 64'(0));
    check("rst_oe", 64'(databus_oe), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err_cnt), 64'(0));
    check("rst_fidx", 64'(first_err_idx), 64'(0));
    check("rst_fvld", 64'(first_err_vld), 64'(0));

    // 21-instruction program with one load and two stores, then 3 NOPs
    for (int i = 0; i < DEPTH; i++) begin
      t_instr[i] = 32'h2001_0000 + i;
      t_daddr[i] = 32'h0000_0100 + i * 4;
      t_load[i]  = '0;
      t_store[i] = 32'h5A00_0000 + i;
      t_flags[i] = 3'b100;
    end
    t_instr[5]  = 32'h8C41_0000; t_daddr[5]  = 32'hFFFF_FFFF; t_load[5]   = 32'hCCCC_CCCC; t_flags[5]  = 3'b110;
    t_instr[11] = 32'hAC42_0000; t_daddr[11] = 32'h0000_1002; t_store[11] = 32'hFFFF_FFFF; t_flags[11] = 3'b101;
    t_instr[17] = 32'hAC43_0000; t_daddr[17] = 32'hCCCC_68AC; t_store[17] = 32'h2222_2222; t_flags[17] = 3'b101;
    for (int i = 21; i < 24; i++) begin t_instr[i] = '0; t_flags[i] = 3'b000; end
    for (int i = 0; i < DEPTH; i++) prog_vec(i);

    run_vec(24, 0, 0, "prog_ok");
    fault_idx = 17;
    run_vec(24, 1, 17, "store_fault");
    fault_idx = -1;

    // reset in the middle of a run
    num_vec = 6'd24;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ibus", 64'(ibus), 64'(0));
    check("midrst_oe", 64'(databus_oe), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    reset = 1'b0;
    load_q.delete();
    tick();
    run_vec(24, 0, 0, "rerun");

    t_flags[0] = 3'b000; prog_vec(0); mode = 1;
    run_vec(1, 0, 0, "x_nochk");
    t_flags[0] = 3'b100; prog_vec(0); mode = 2;
    run_vec(1, 1, 0, "z_daddr");
    t_flags[0] = 3'b101; prog_vec(0); mode = 3;
    run_vec(1, 2, 0, "both_wrong");
    mode = 0;

    run_vec(0, 0, 0, "zero_vec");
    for (int i = 0; i < DEPTH; i++) begin
      t_instr[i] = 32'h2001_0000 + i;
      t_load[i]  = '0;
      t_flags[i] = 3'b101;
      prog_vec(i);
    end
    fault_idx = DEPTH - 1;
    run_vec(DEPTH, 1, DEPTH - 1, "full_depth");
    fault_idx = -1;
    mode = 3;
    run_vec(DEPTH, 2 * DEPTH, 0, "all_fail");
    check("sat_small_err", 64'(err_cnt_s), 64'(31));
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_vector_checker.md
Name: bus_vector_checker

Overview:
- Synthesizable, parametrised successor to the 4-stage CPU bench driver.
- Replays a loaded instruction program onto ibus, one word per clock.
- Returns load data and checks data address and store data LAT cycles after each instruction issues, with per-field don't-care masks.
- Reports an error count and the index of the first failing vector, so CPU regression runs on FPGA or in simulation without a hand-written bench.

Parameters:
DW, 32, instruction/address/data width
DEPTH, 32, number of vector entries
AW, $clog2(DEPTH), vector index width
LAT, 3, issue-to-check latency in cycles (4-stage pipe = 3); legal 1..15
ERRW, 16, error counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
prog_we  in  1  vector memory write strobe
prog_addr  in  AW  vector index to write
prog_field  in  3  0=instr 1=exp_daddr 2=load_data 3=exp_store 4=flags{daddr_chk,load_vld,store_chk}
prog_wdata  in  DW  write data (flags in bits [2:0])
num_vec  in  AW+1  number of vectors to run, 0..DEPTH
start  in  1  one-cycle start pulse, honoured in IDLE and DONE only
ibus  out  DW  instruction to DUT
daddrbus  in  DW  DUT data address
databus_in  in  DW  DUT store data as seen on the bus
databus_out  out  DW  load data driven to DUT
databus_oe  out  1  load data drive enable
busy  out  1  RUN or DRAIN
done  out  1  run complete, held until start or reset
err_cnt  out  ERRW  mismatch count, saturating
first_err_idx  out  AW  index of first failing vector
first_err_vld  out  1  first_err_idx valid

Behaviour:
- Reset values: ibus=0, databus_out=0, databus_oe=0, busy=0, done=0, err_cnt=0, first_err_idx=0, first_err_vld=0. State goes to IDLE.
- Vector memory contents are not cleared by reset.
- prog_we writes in any state. A write to an index still to be issued or checked during a run takes effect at its next read; this is legal but unsupported.
- States:
  - IDLE: start -> RUN, clears err_cnt and first_err_*; issue counter k=0.
  - RUN: at each rising edge, ibus<=instr[k], k<=k+1. When k reaches num_vec-1 the next state is DRAIN.
  - DRAIN: ibus<=0 (NOP) for LAT cycles, then DONE.
  - DONE: done=1, busy=0. start -> RUN with the same clearing as IDLE.
  - num_vec=0: start goes straight to DRAIN; no checks, done after LAT cycles.
- Check pipeline: a shift register of depth LAT carries {idx,valid}. An entry issued at edge n is checked at edge n+LAT, sampling daddrbus and databus_in at that edge.
- Check rules (no check on invalid/NOP slots):
  - daddr_chk=1 and daddrbus !== exp_daddr is one error.
  - store_chk=1 and databus_in !== exp_store is one error.
  - Compares are 4-state. X or Z on the bus is a mismatch.
- Both fields failing on the same edge add 2. err_cnt saturates at 2^ERRW-1.
- first_err_idx/first_err_vld latch on the first failing edge of a run only.
- Load return: for a slot with load_vld=1, databus_out=load_data and databus_oe=1 during the cycle after issue+LAT-1. This places data valid before the check edge, matching the bench timing where load data is written half a cycle ahead. Otherwise databus_oe=0.
- Reset mid-run aborts immediately: state IDLE, pipeline valids cleared, all outputs at reset values.
- start while busy is ignored.

Decomposition:
- Package bvc_pkg:
  - state enum {IDLE,RUN,DRAIN,DONE}
  - field-select constants F_INSTR..F_FLAGS
  - flag bit positions
  - NOP constant 0
- One sub-module: bvc_vec_mem, a 5-field DEPTH-entry register file with one write port and two read ports (issue index, check index).

Test Plan:
1. Load the 21-instruction MIPS program plus 3 NOPs, LAT=3, correct DUT model. Expected: LW addr FFFFFFFF with load CCCCCCCC; SW addr 00001002 with store FFFFFFFF; SW addr CCCC68AC with store 22222222. Required: err_cnt=0, done after 24+3 cycles.
2. Same program with a model storing 22222223 at vector 17 -> err_cnt=1, first_err_idx=17, first_err_vld=1.
3. Vector with daddr_chk=0, store_chk=0 and daddrbus=X -> err_cnt stays 0. Set daddr_chk=1 with daddrbus=Z -> err_cnt=1.
4. Vector with both fields wrong -> err_cnt=2. Force 70000 errors with ERRW=16 -> err_cnt=FFFF.
5. reset asserted at cycle 10 of RUN -> next cycle busy=0, ibus=0, databus_oe=0. A new start reruns from index 0 with err_cnt=0.
6. num_vec=0 -> done after LAT cycles, err_cnt=0. num_vec=DEPTH -> last index DEPTH-1 checked, k wraps without overrun.
